// File: rtl/atom_kbd_pkg.sv
// Shared types and constants for the Atom PS/2 keyboard: receiver states,
// scancode prefixes and keymap entry format.
package atom_kbd_pkg;
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  typedef enum logic [2:0] {
    K_MATRIX, K_LSHIFT, K_RSHIFT, K_LCTRL, K_RCTRL, K_REPT, K_BREAK
  } key_kind_t;

  typedef struct packed {
    logic      valid;
    key_kind_t kind;
    logic [3:0] row;
    logic [2:0] col;
  } key_ent_t;

  function automatic key_ent_t km(input int row, input int col);
    km = '{valid: 1'b1, kind: K_MATRIX, row: 4'(row), col: 3'(col)};
  endfunction

  function automatic key_ent_t ks(input key_kind_t kind);
    ks = '{valid: 1'b1, kind: kind, row: 4'd0, col: 3'd0};
  endfunction
endpackage

// File: rtl/atom_keymap.sv
// Combinational scancode ROM: {ext, code} -> Atom matrix position or special key.
// F12 is only mapped when ATOM_KBD_BREAK_EN is defined.
module atom_keymap import atom_kbd_pkg::*; (
  input  logic       ext,
  input  logic [7:0] code,
  output key_ent_t   ent
);
  always_comb begin
    ent = '0;
    case ({ext, code})
      9'h029: ent = km(9, 0);  9'h01C: ent = km(9, 1);  9'h032: ent = km(9, 2);
      9'h021: ent = km(9, 3);  9'h023: ent = km(9, 4);  9'h024: ent = km(9, 5);
      9'h02B: ent = km(8, 0);  9'h034: ent = km(8, 1);  9'h033: ent = km(8, 2);
      9'h043: ent = km(8, 3);  9'h03B: ent = km(8, 4);  9'h042: ent = km(8, 5);
      9'h04B: ent = km(7, 0);  9'h03A: ent = km(7, 1);  9'h031: ent = km(7, 2);
      9'h044: ent = km(7, 3);  9'h04D: ent = km(7, 4);  9'h015: ent = km(7, 5);
      9'h02D: ent = km(6, 0);  9'h01B: ent = km(6, 1);  9'h02C: ent = km(6, 2);
      9'h03C: ent = km(6, 3);  9'h02A: ent = km(6, 4);  9'h01D: ent = km(6, 5);
      9'h022: ent = km(5, 0);  9'h035: ent = km(5, 1);  9'h01A: ent = km(5, 2);
      9'h045: ent = km(5, 3);  9'h016: ent = km(5, 4);  9'h01E: ent = km(5, 5);
      9'h026: ent = km(4, 0);  9'h025: ent = km(4, 1);  9'h02E: ent = km(4, 2);
      9'h036: ent = km(4, 3);  9'h03D: ent = km(4, 4);  9'h03E: ent = km(4, 5);
      9'h046: ent = km(3, 0);  9'h04E: ent = km(3, 1);  9'h04C: ent = km(3, 2);
      9'h041: ent = km(3, 3);  9'h049: ent = km(3, 4);  9'h04A: ent = km(3, 5);
      // Row 2: RETURN, DEL, ESC, COPY (End), cursor up, cursor left
      9'h05A: ent = km(2, 0);  9'h066: ent = km(2, 1);  9'h076: ent = km(2, 2);
      9'h169: ent = km(2, 3);  9'h175: ent = km(2, 4);  9'h16B: ent = km(2, 5);
      9'h054: ent = km(1, 0);  9'h05B: ent = km(1, 1);  9'h05D: ent = km(1, 2);
      9'h052: ent = km(1, 3);  9'h055: ent = km(1, 4);  9'h058: ent = km(1, 5);
      9'h00E: ent = km(0, 0);  9'h172: ent = km(0, 1);  9'h174: ent = km(0, 2);
      9'h00D: ent = km(0, 3);
      9'h012: ent = ks(K_LSHIFT);
      9'h059: ent = ks(K_RSHIFT);
      9'h014: ent = ks(K_LCTRL);
      9'h114: ent = ks(K_RCTRL);
      9'h011: ent = ks(K_REPT);
`ifdef ATOM_KBD_BREAK_EN
      9'h007: ent = ks(K_BREAK);
`endif
      default: ent = '0;
    endcase
  end
endmodule

// File: rtl/atom_ps2_keyboard.sv
// PS/2 receiver and 10x6 Atom key matrix feeding the PIO keyboard inputs.
// Define ATOM_KBD_BREAK_EN to make F12 drive break_req.
module atom_ps2_keyboard import atom_kbd_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [3:0] key_row,
  output logic [7:0] kbd_out,
  output logic       rept_n,
  output logic       break_req
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_prev, fall, dat_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  rx_state_t      state, state_nxt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg, rx_byte;
  logic           par_bit, byte_ok, byte_valid, timeout;
  logic [TW-1:0]  timer;

  always_comb begin
    state_nxt = state;
    byte_ok   = 1'b0;
    timeout   = (state != ST_IDLE) && (timer == TW'(TIMEOUT_CYCLES - 1));
    if (fall) begin
      case (state)
        ST_IDLE:   if (!dat_s) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP: begin
          state_nxt = ST_IDLE;
          byte_ok   = dat_s & (^{shreg, par_bit});
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      timer      <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
    end else begin
      state      <= state_nxt;
      byte_valid <= byte_ok;
      if (byte_ok) rx_byte <= shreg;
      // The watchdog only runs inside a frame; idle time between frames is unbounded.
      if (fall || state == ST_IDLE) timer <= '0;
      else                          timer <= timer + 1'b1;
      if (fall) begin
        if (state == ST_IDLE) bit_cnt <= '0;
        if (state == ST_DATA) begin
          shreg   <= {dat_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == ST_PARITY) par_bit <= dat_s;
      end
    end
  end

  key_ent_t        ent;
  logic            ext, brk, lsh, rsh, lct, rct, rept;
  logic [9:0][5:0] matrix;
`ifdef ATOM_KBD_BREAK_EN
  logic            f12;
`endif

  atom_keymap u_keymap (.ext(ext), .code(rx_byte), .ent(ent));

  always_ff @(posedge clk) begin
    if (reset) begin
      ext <= 1'b0; brk <= 1'b0; matrix <= '0;
      lsh <= 1'b0; rsh <= 1'b0; lct <= 1'b0; rct <= 1'b0; rept <= 1'b0;
`ifdef ATOM_KBD_BREAK_EN
      f12 <= 1'b0;
`endif
    end else if (byte_valid) begin
      if (rx_byte == SC_EXT)      ext <= 1'b1;
      else if (rx_byte == SC_BRK) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (ent.valid) begin
          case (ent.kind)
            K_MATRIX: matrix[ent.row][ent.col] <= ~brk;
            K_LSHIFT: lsh  <= ~brk;
            K_RSHIFT: rsh  <= ~brk;
            K_LCTRL:  lct  <= ~brk;
            K_RCTRL:  rct  <= ~brk;
            K_REPT:   rept <= ~brk;
`ifdef ATOM_KBD_BREAK_EN
            K_BREAK:  f12  <= ~brk;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  logic [5:0] col_n;
  assign col_n = (key_row > 4'd9) ? 6'h3F : ~matrix[key_row];

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_out <= 8'hFF;
      rept_n  <= 1'b1;
    end else begin
      kbd_out <= {~(lsh | rsh), ~(lct | rct), col_n};
      rept_n  <= ~rept;
    end
  end

`ifdef ATOM_KBD_BREAK_EN
  always_ff @(posedge clk) begin
    if (reset) break_req <= 1'b0;
    else       break_req <= f12;
  end
`else
  assign break_req = 1'b0;
`endif
endmodule
